// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: character handshake and serial line bundle.
// master = character source, slave = framer.
interface uart_tx_frame_if #(
  parameter int NrOfDataBits = 8
);
  logic                    startTransmission;
  logic [NrOfDataBits-1:0] dataBits;
  logic                    busy;
  logic                    done;
  logic                    tx;

  modport master (
    output startTransmission,
    output dataBits,
    input  busy,
    input  done,
    input  tx
  );

  modport slave (
    input  startTransmission,
    input  dataBits,
    output busy,
    output done,
    output tx
  );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer, start/data/parity/stop.
// Own baud counter; tx, busy and done all come straight from flops.
module uart_tx_frame #(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int NrOfDataBits   = 8,
  parameter int ParityMode     = 0,
  parameter int NrOfStopBits   = 1,
  parameter int MsbFirst       = 0
) (
  input logic            clock,
  input logic            reset,
  uart_tx_frame_if.slave bus
);

  localparam int BitTicks = ClockFrequency / BaudRate;
  localparam int CntW =
    (BitTicks > 2) ? $clog2(BitTicks) : 1;
  localparam logic [CntW-1:0] LastTick =
    CntW'(BitTicks - 1);
  localparam logic [3:0] LastData =
    4'(NrOfDataBits - 1);
  localparam logic [3:0] LastStop =
    4'(NrOfStopBits - 1);
  localparam logic OddPar = (ParityMode == 2);
  localparam logic HasPar = (ParityMode != 0);
  localparam logic Msb    = (MsbFirst != 0);

  if (BitTicks < 2) begin : g_bad_baud
    $error("uart_tx_frame: BitTicks must be >= 2");
  end
  if (NrOfDataBits < 5 || NrOfDataBits > 9)
  begin : g_bad_width
    $error("uart_tx_frame: NrOfDataBits 5..9");
  end
  if (ParityMode < 0 || ParityMode > 2)
  begin : g_bad_parity
    $error("uart_tx_frame: ParityMode 0..2");
  end
  if (NrOfStopBits < 1 || NrOfStopBits > 2)
  begin : g_bad_stop
    $error("uart_tx_frame: NrOfStopBits 1 or 2");
  end

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
    Parity,
    Stop
  } state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic [NrOfDataBits-1:0] sh_q, sh_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    tick;
  logic                    out_bit;
  logic [NrOfDataBits-1:0] sh_next;

  assign tick = (baud_q == LastTick);

  // Next character bit and the register after it leaves.
  always_comb begin
    out_bit = sh_q[0];
    sh_next = {1'b0, sh_q[NrOfDataBits-1:1]};
    if (Msb) begin
      out_bit = sh_q[NrOfDataBits-1];
      sh_next = {sh_q[NrOfDataBits-2:0], 1'b0};
    end
  end

  // Frame sequencing: bit slots, tx value and handshake flags.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != Idle) begin
      baud_d = tick ? '0 : baud_q + CntW'(1);
    end

    unique case (state_q)
      Idle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
        if (bus.startTransmission) begin
          sh_d    = bus.dataBits;
          par_d   = (^bus.dataBits) ^ OddPar;
          state_d = Start;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      Start: begin
        if (tick) begin
          state_d = Data;
          bit_d   = '0;
          tx_d    = out_bit;
          sh_d    = sh_next;
        end
      end
      Data: begin
        if (tick) begin
          if (bit_q == LastData) begin
            bit_d = '0;
            if (HasPar) begin
              state_d = Parity;
              tx_d    = par_q;
            end else begin
              state_d = Stop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = out_bit;
            sh_d  = sh_next;
          end
        end
      end
      Parity: begin
        if (tick) begin
          state_d = Stop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      Stop: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_q == LastStop) begin
            state_d = Idle;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = Idle;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Idle;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four framer configs checked cycle by cycle
// against a queue of expected frames.
module tb_uart_tx_frame;

  localparam int T = 10;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start [4];
  logic [7:0] din   [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       done  [4];
  int         cyc  = 0;
  int         nvec = 0;
  int         nerr = 0;
  exp_t       sbq [4][$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_frame_if #(.NrOfDataBits(8)) bus0 ();
  uart_tx_frame_if #(.NrOfDataBits(8)) bus1 ();
  uart_tx_frame_if #(.NrOfDataBits(8)) bus2 ();
  uart_tx_frame_if #(.NrOfDataBits(8)) bus3 ();

  assign bus0.startTransmission = start[0];
  assign bus1.startTransmission = start[1];
  assign bus2.startTransmission = start[2];
  assign bus3.startTransmission = start[3];
  assign bus0.dataBits = din[0];
  assign bus1.dataBits = din[1];
  assign bus2.dataBits = din[2];
  assign bus3.dataBits = din[3];
  assign tx[0] = bus0.tx;
  assign tx[1] = bus1.tx;
  assign tx[2] = bus2.tx;
  assign tx[3] = bus3.tx;
  assign busy[0] = bus0.busy;
  assign busy[1] = bus1.busy;
  assign busy[2] = bus2.busy;
  assign busy[3] = bus3.busy;
  assign done[0] = bus0.done;
  assign done[1] = bus1.done;
  assign done[2] = bus2.done;
  assign done[3] = bus3.done;

  uart_tx_frame #(
    .ClockFrequency(24_000_000),
    .BaudRate(2_400_000),
    .NrOfDataBits(8),
    .ParityMode(0),
    .NrOfStopBits(1),
    .MsbFirst(0)
  ) u_dut0 (
    .clock(clock),
    .reset(reset),
    .bus(bus0)
  );

  uart_tx_frame #(
    .ClockFrequency(24_000_000),
    .BaudRate(2_400_000),
    .NrOfDataBits(8),
    .ParityMode(1),
    .NrOfStopBits(1),
    .MsbFirst(0)
  ) u_dut1 (
    .clock(clock),
    .reset(reset),
    .bus(bus1)
  );

  uart_tx_frame #(
    .ClockFrequency(24_000_000),
    .BaudRate(2_400_000),
    .NrOfDataBits(8),
    .ParityMode(2),
    .NrOfStopBits(1),
    .MsbFirst(0)
  ) u_dut2 (
    .clock(clock),
    .reset(reset),
    .bus(bus2)
  );

  uart_tx_frame #(
    .ClockFrequency(24_000_000),
    .BaudRate(2_400_000),
    .NrOfDataBits(8),
    .ParityMode(0),
    .NrOfStopBits(2),
    .MsbFirst(1)
  ) u_dut3 (
    .clock(clock),
    .reset(reset),
    .bus(bus3)
  );

  function automatic int pm_of(int k);
    if (k == 1) return 1;
    if (k == 2) return 2;
    return 0;
  endfunction

  function automatic int stops_of(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic bit msb_of(int k);
    return (k == 3);
  endfunction

  function automatic int flen(int k);
    return 1 + 8 + ((pm_of(k) != 0) ? 1 : 0)
      + stops_of(k);
  endfunction

  // Expected line level for bit slot b of a frame.
  function automatic logic exp_bit(
    int k, logic [7:0] d, int b);
    logic p;
    if (b == 0) return 1'b0;
    if (b <= 8) begin
      if (msb_of(k)) return d[8-b];
      return d[b-1];
    end
    if (pm_of(k) != 0 && b == 9) begin
      p = ^d;
      if (pm_of(k) == 2) p = ~p;
      return p;
    end
    return 1'b1;
  endfunction

  task automatic chk(
    string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h cyc %0d",
        tag, got, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_mon
    bit   act   = 1'b0;
    bit   rst_q = 1'b1;
    int   c     = 0;
    exp_t e;

    always @(negedge clock) begin
      if (rst_q) begin
        chk($sformatf("d%0d.rst_tx", k), 32'(tx[k]), 1);
        chk($sformatf("d%0d.rst_busy", k),
          32'(busy[k]), 0);
        chk($sformatf("d%0d.rst_done", k),
          32'(done[k]), 0);
        act = 1'b0;
      end else begin
        if (!act && sbq[k].size() > 0
            && sbq[k][0].acc == cyc) begin
          e   = sbq[k].pop_front();
          act = 1'b1;
          c   = 0;
        end
        if (act) begin
          if (c < flen(k) * T) begin
            chk($sformatf("d%0d.tx[%0d]", k, c),
              32'(tx[k]), 32'(exp_bit(k, e.d, c / T)));
            chk($sformatf("d%0d.busy[%0d]", k, c),
              32'(busy[k]), 1);
            chk($sformatf("d%0d.done[%0d]", k, c),
              32'(done[k]), 0);
            c++;
          end else begin
            chk($sformatf("d%0d.done_end", k),
              32'(done[k]), 1);
            chk($sformatf("d%0d.busy_end", k),
              32'(busy[k]), 0);
            chk($sformatf("d%0d.tx_end", k),
              32'(tx[k]), 1);
            act = 1'b0;
          end
        end else begin
          chk($sformatf("d%0d.idle_tx", k),
            32'(tx[k]), 1);
          chk($sformatf("d%0d.idle_busy", k),
            32'(busy[k]), 0);
          chk($sformatf("d%0d.idle_done", k),
            32'(done[k]), 0);
        end
      end
      rst_q = reset;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) step(1);
  endtask

  task automatic req(int k, logic [7:0] d);
    exp_t e;
    start[k] = 1'b1;
    din[k]   = d;
    e.d      = d;
    e.acc    = cyc + 1;
    sbq[k].push_back(e);
    step(1);
    start[k] = 1'b0;
  endtask

  task automatic push(int k, logic [7:0] d, int acc);
    exp_t e;
    e.d   = d;
    e.acc = acc;
    sbq[k].push_back(e);
  endtask

  initial begin
    int a;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0;
      din[k]   = 8'h00;
    end
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);

    fork
      req(0, 8'hBA);
      req(1, 8'hBA);
      req(2, 8'hBA);
      req(3, 8'hBA);
    join
    step(130);

    a = cyc + 1;
    req(0, 8'hBA);
    wait_cyc(a + 30);
    start[0] = 1'b1;
    din[0]   = 8'h00;
    step(1);
    start[0] = 1'b0;
    step(110);

    a = cyc + 1;
    push(0, 8'h3C, a);
    push(0, 8'hA5, a + 101);
    push(0, 8'h0F, a + 202);
    start[0] = 1'b1;
    din[0]   = 8'h3C;
    wait_cyc(a);
    din[0] = 8'hA5;
    wait_cyc(a + 101);
    din[0] = 8'h0F;
    wait_cyc(a + 202);
    start[0] = 1'b0;
    step(110);

    a = cyc + 1;
    req(0, 8'h5C);
    wait_cyc(a + 44);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    req(0, 8'hBA);
    step(110);

    fork
      req(1, 8'h07);
      req(2, 8'h07);
      req(3, 8'h81);
    join
    step(130);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d.sbq_empty", k),
        32'(sbq[k].size()), 0);
    end
    chk("d0.frame_open", 32'(g_mon[0].act), 0);
    chk("d1.frame_open", 32'(g_mon[1].act), 0);
    chk("d2.frame_open", 32'(g_mon[2].act), 0);
    chk("d3.frame_open", 32'(g_mon[3].act), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
      nvec, nerr);
    $finish;
  end

endmodule
